// File: rtl/cdb_broadcast_if.sv
// cdb_broadcast_if: FU result handshake, rollback inputs and CDB broadcast outputs
interface cdb_broadcast_if #(
  parameter int NUM_FU   = 5,
  parameter int NUM_PR   = 64,
  parameter int ROB_SIZE = 32
);
  localparam int PR_W  = $clog2(NUM_PR);
  localparam int ROB_W = $clog2(ROB_SIZE);
  logic [NUM_FU-1:0] fu_valid;
  logic [NUM_FU-1:0] fu_ready;
  logic [PR_W-1:0]   fu_T_idx   [NUM_FU];
  logic [63:0]       fu_T_value [NUM_FU];
  logic [ROB_W-1:0]  fu_rob_idx [NUM_FU];
  logic [ROB_W-1:0]  rob_head;
  logic              rollback_en;
  logic [ROB_W-1:0]  rollback_rob_idx;
  logic              cdb_valid;
  logic [PR_W-1:0]   cdb_T_idx;
  logic [63:0]       cdb_T_value;
  logic [ROB_W-1:0]  cdb_rob_idx;
  logic              pr_write_en;
  modport master (
    output fu_valid, fu_T_idx, fu_T_value, fu_rob_idx, rob_head, rollback_en, rollback_rob_idx,
    input  fu_ready, cdb_valid, cdb_T_idx, cdb_T_value, cdb_rob_idx, pr_write_en
  );
  modport slave (
    input  fu_valid, fu_T_idx, fu_T_value, fu_rob_idx, rob_head, rollback_en, rollback_rob_idx,
    output fu_ready, cdb_valid, cdb_T_idx, cdb_T_value, cdb_rob_idx, pr_write_en
  );
endinterface

// File: rtl/cdb_broadcast.sv
// cdb_broadcast: buffers FU results per unit and broadcasts one per cycle round-robin with rollback squash
module cdb_broadcast #(
  parameter int NUM_FU   = 5,
  parameter int NUM_PR   = 64,
  parameter int ROB_SIZE = 32,
  parameter int ZERO_PR  = 31
) (
  input logic           clk_i,
  input logic           rst_i,
  input logic           en_i,
  cdb_broadcast_if.slave bus
);
  localparam int PR_W  = $clog2(NUM_PR);
  localparam int ROB_W = $clog2(ROB_SIZE);
  localparam int FU_W  = $clog2(NUM_FU);
  logic [NUM_FU-1:0] buf_valid_q, buf_valid_d;
  logic [PR_W-1:0]   buf_T_idx_q   [NUM_FU];
  logic [PR_W-1:0]   buf_T_idx_d   [NUM_FU];
  logic [63:0]       buf_T_value_q [NUM_FU];
  logic [63:0]       buf_T_value_d [NUM_FU];
  logic [ROB_W-1:0]  buf_rob_idx_q [NUM_FU];
  logic [ROB_W-1:0]  buf_rob_idx_d [NUM_FU];
  logic [FU_W-1:0]   rr_q, rr_d, gnt_idx, scan;
  logic [NUM_FU-1:0] squash, in_squash, gnt, xfer;
  logic [ROB_W-1:0]  rb_age;
  logic              found;
  function automatic logic [ROB_W-1:0] age(input logic [ROB_W-1:0] x, input logic [ROB_W-1:0] h);
    return x - h;
  endfunction
  // squash flags for buffered and incoming results; a rollback is ignored while en is low
  always_comb begin
    squash = '0;
    in_squash = '0;
    rb_age = age(bus.rollback_rob_idx, bus.rob_head);
    for (int i = 0; i < NUM_FU; i++) begin
      squash[i] = en_i && bus.rollback_en && age(buf_rob_idx_q[i], bus.rob_head) > rb_age;
      in_squash[i] = en_i && bus.rollback_en && age(bus.fu_rob_idx[i], bus.rob_head) > rb_age;
    end
  end
  // round-robin grant: first surviving buffer at or after rr_q
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    scan = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan = FU_W'((int'(rr_q) + k) % NUM_FU);
      if (!found && en_i && buf_valid_q[scan] && !squash[scan]) begin
        found = 1'b1;
        gnt_idx = scan;
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
    rr_d = !found ? rr_q : gnt_idx == FU_W'(NUM_FU - 1) ? '0 : gnt_idx + 1'b1;
  end
  assign bus.cdb_valid   = found;
  assign bus.cdb_T_idx   = found ? buf_T_idx_q[gnt_idx] : '0;
  assign bus.cdb_T_value = found ? buf_T_value_q[gnt_idx] : '0;
  assign bus.cdb_rob_idx = found ? buf_rob_idx_q[gnt_idx] : '0;
  assign bus.pr_write_en = found && bus.cdb_T_idx != PR_W'(ZERO_PR);
  assign bus.fu_ready    = {NUM_FU{en_i && !rst_i}} & (~buf_valid_q | gnt | squash);
  assign xfer            = bus.fu_valid & bus.fu_ready;
  // slot update: refill wins over drain, squashed arrivals are swallowed
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_T_idx_d = buf_T_idx_q;
    buf_T_value_d = buf_T_value_q;
    buf_rob_idx_d = buf_rob_idx_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (xfer[i]) begin
        buf_valid_d[i] = !in_squash[i];
        buf_T_idx_d[i] = bus.fu_T_idx[i];
        buf_T_value_d[i] = bus.fu_T_value[i];
        buf_rob_idx_d[i] = bus.fu_rob_idx[i];
      end else if (gnt[i] || squash[i]) begin
        buf_valid_d[i] = 1'b0;
      end
    end
  end
  // control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid_q <= '0;
      rr_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_q <= rr_d;
    end
  end
  // payload registers are qualified by buf_valid_q and need no reset
  always_ff @(posedge clk_i) begin
    buf_T_idx_q <= buf_T_idx_d;
    buf_T_value_q <= buf_T_value_d;
    buf_rob_idx_q <= buf_rob_idx_d;
  end
endmodule
